// File: rtl/dds_phase_ctrl.sv
// DDS phase sequencer: holds tuning config, runs the phase accumulator and
// issues sine-ROM read addresses for tone, sweep and burst modes.
module dds_phase_ctrl #(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_100m,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_mode,
    input  logic [ACC_W-1:0]  cfg_fword,
    input  logic [ADDR_W-1:0] cfg_pword,
    input  logic [ACC_W-1:0]  cfg_fstep,
    input  logic [ACC_W-1:0]  cfg_fstop,
    input  logic [CNT_W-1:0]  cfg_ncycles,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rd_address,
    output logic              addr_valid,
    output logic              sample_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        mode_q;
    logic [ACC_W-1:0]  fword_q, fstep_q, fstop_q;
    logic [ADDR_W-1:0] pword_q;
    logic [CNT_W-1:0]  ncycles_q;

    logic [ACC_W-1:0]  acc, fword_cur;
    logic [CNT_W-1:0]  wrap_cnt;
    logic              finish_q;

    logic              cfg_fire, launch, step, carry, wrap, last;
    logic [ACC_W-1:0]  acc_src, f_src;
    logic [ADDR_W-1:0] p_src;
    logic [ACC_W:0]    sum, fnext_sum;
    logic [ACC_W-1:0]  fnext;
    logic [CNT_W-1:0]  ncyc_eff;
    logic [CNT_W:0]    wrap_cnt_inc;
    logic              burst_last, sweep_last;

    assign cfg_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign cfg_fire  = cfg_valid & cfg_ready;

    // The start edge already issues the first address (acc treated as 0), so
    // addr_valid rises one cycle after start; config offered with start is used.
    assign launch = (state == S_IDLE) & start & ~stop;
    assign step   = launch | ((state == S_RUN) & ~finish_q & ~stop);

    assign acc_src = launch ? '0 : acc;
    assign f_src   = launch ? (cfg_fire ? cfg_fword : fword_q) : fword_cur;
    assign p_src   = launch ? (cfg_fire ? cfg_pword : pword_q) : pword_q;

    assign sum   = {1'b0, acc_src} + {1'b0, f_src};
    assign carry = sum[ACC_W];
    assign wrap  = step & carry;

    assign fnext_sum = {1'b0, fword_cur} + {1'b0, fstep_q};
    assign fnext     = (fnext_sum[ACC_W] || (fnext_sum[ACC_W-1:0] > fstop_q))
                       ? fstop_q : fnext_sum[ACC_W-1:0];

    assign ncyc_eff     = (ncycles_q == '0) ? CNT_W'(1) : ncycles_q;
    assign wrap_cnt_inc = {1'b0, wrap_cnt} + (CNT_W+1)'(1);
    assign burst_last   = (wrap_cnt_inc >= {1'b0, ncyc_eff});
    assign sweep_last   = (fword_cur >= fstop_q) || (fstep_q == '0);

    assign last = wrap & (((mode_q == 2'd2) & burst_last) |
                          ((mode_q == 2'd1) & sweep_last));

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // The final wrap's address is issued while still in RUN; finish_q then
    // moves to DONE one cycle later so DONE never overlaps a live address.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (launch)   state_nxt = S_RUN;
            S_RUN:   if (finish_q) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (stop) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            mode_q       <= '0;
            fword_q      <= '0;
            pword_q      <= '0;
            fstep_q      <= '0;
            fstop_q      <= '0;
            ncycles_q    <= '0;
            acc          <= '0;
            fword_cur    <= '0;
            wrap_cnt     <= '0;
            finish_q     <= 1'b0;
            rd_address   <= '0;
            addr_valid   <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= addr_valid;
            if (cfg_fire) begin
                mode_q    <= cfg_mode;
                fword_q   <= cfg_fword;
                pword_q   <= cfg_pword;
                fstep_q   <= cfg_fstep;
                fstop_q   <= cfg_fstop;
                ncycles_q <= cfg_ncycles;
            end
            if (step) begin
                acc        <= sum[ACC_W-1:0];
                rd_address <= acc_src[ACC_W-1 -: ADDR_W] + p_src;
                addr_valid <= 1'b1;
                if (launch) begin
                    fword_cur <= f_src;
                    wrap_cnt  <= '0;
                    finish_q  <= 1'b0;
                end else if (wrap) begin
                    wrap_cnt <= wrap_cnt_inc[CNT_W-1:0];
                    if (mode_q == 2'd1) fword_cur <= fnext;
                    if (last)           finish_q  <= 1'b1;
                end
            end else begin
                addr_valid <= 1'b0;
                finish_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Directed bench for dds_phase_ctrl: table of mode/config vectors plus
// hand-written stop, reset and handshake sequences.
module tb_dds_phase_ctrl;

    logic        clk_100m = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_fword;
    logic [7:0]  cfg_pword;
    logic [31:0] cfg_fstep;
    logic [31:0] cfg_fstop;
    logic [15:0] cfg_ncycles;
    logic        start;
    logic        stop;
    logic [7:0]  rd_address;
    logic        addr_valid;
    logic        sample_valid;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;

    dds_phase_ctrl #(.ACC_W(32), .ADDR_W(8), .CNT_W(16)) dut (
        .clk_100m    (clk_100m),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_mode    (cfg_mode),
        .cfg_fword   (cfg_fword),
        .cfg_pword   (cfg_pword),
        .cfg_fstep   (cfg_fstep),
        .cfg_fstop   (cfg_fstop),
        .cfg_ncycles (cfg_ncycles),
        .start       (start),
        .stop        (stop),
        .rd_address  (rd_address),
        .addr_valid  (addr_valid),
        .sample_valid(sample_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk_100m = ~clk_100m;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] fword;
        logic [7:0]  pword;
        logic [31:0] fstep;
        logic [31:0] fstop;
        logic [15:0] ncyc;
        logic [7:0]  exp_first;
        logic [7:0]  exp_idx3;
        int          exp_nvalid;   // 0 = free-running tone
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    // sample_valid must equal addr_valid as it was one cycle earlier
    logic av_neg = 1'b0;
    always @(negedge clk_100m) av_neg = addr_valid;
    always @(posedge clk_100m) begin
        #1;
        if (!rst) chk("sample_valid_lag", {63'd0, sample_valid}, {63'd0, av_neg});
    end

    task automatic load_cfg(input vec_t v);
        cfg_mode    = v.mode;
        cfg_fword   = v.fword;
        cfg_pword   = v.pword;
        cfg_fstep   = v.fstep;
        cfg_fstop   = v.fstop;
        cfg_ncycles = v.ncyc;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nval;
        int ndone;
        load_cfg(v);
        cfg_valid = 1'b1;
        if (idx % 2 == 0) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            cfg_valid = 1'b0;
        end else begin
            tick();
            cfg_valid = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk($sformatf("v%0d_first_valid", idx), {63'd0, addr_valid}, 64'd1);
        chk($sformatf("v%0d_first_addr", idx), {56'd0, rd_address}, {56'd0, v.exp_first});
        chk($sformatf("v%0d_busy", idx), {63'd0, busy}, 64'd1);
        nval = 0;
        ndone = 0;
        if (v.exp_nvalid == 0) begin
            for (int c = 0; c < 300; c++) begin
                if (addr_valid) begin
                    if (nval == 3) chk($sformatf("v%0d_addr3", idx), {56'd0, rd_address}, {56'd0, v.exp_idx3});
                    nval++;
                end
                if (done) ndone++;
                tick();
            end
            chk($sformatf("v%0d_tone_nvalid", idx), 64'(nval), 64'd300);
            chk($sformatf("v%0d_tone_nodone", idx), 64'(ndone), 64'd0);
            stop = 1'b1;
            tick();
            stop = 1'b0;
            chk($sformatf("v%0d_stop_av", idx), {63'd0, addr_valid}, 64'd0);
            chk($sformatf("v%0d_stop_ready", idx), {63'd0, cfg_ready}, 64'd1);
        end else begin
            for (int c = 0; c < 400; c++) begin
                if (addr_valid) begin
                    if (nval == 3) chk($sformatf("v%0d_addr3", idx), {56'd0, rd_address}, {56'd0, v.exp_idx3});
                    nval++;
                end
                if (done) begin
                    ndone++;
                    chk($sformatf("v%0d_done_av", idx), {63'd0, addr_valid}, 64'd0);
                    break;
                end
                tick();
            end
            chk($sformatf("v%0d_nvalid", idx), 64'(nval), 64'(v.exp_nvalid));
            chk($sformatf("v%0d_done_seen", idx), 64'(ndone), 64'd1);
            chk($sformatf("v%0d_done_busy", idx), {63'd0, busy}, 64'd0);
            tick();
            chk($sformatf("v%0d_done_pulse", idx), {63'd0, done}, 64'd0);
            chk($sformatf("v%0d_idle_ready", idx), {63'd0, cfg_ready}, 64'd1);
            stop = 1'b1;
            tick();
            stop = 1'b0;
        end
    endtask

    initial begin
        vec_t b;
        rst = 1'b1;
        cfg_valid = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        cfg_mode = '0; cfg_fword = '0; cfg_pword = '0;
        cfg_fstep = '0; cfg_fstop = '0; cfg_ncycles = '0;

        //          mode  fword          pword  fstep          fstop          ncyc   first  idx3  nvalid
        vecs[0] = '{2'd0, 32'h0100_0000, 8'd0,   32'd0,         32'd0,         16'd0, 8'd0,   8'd3,   0};
        vecs[1] = '{2'd0, 32'h0400_0000, 8'd64,  32'd0,         32'd0,         16'd0, 8'd64,  8'd76,  0};
        vecs[2] = '{2'd2, 32'h1000_0000, 8'd0,   32'd0,         32'd0,         16'd3, 8'd0,   8'd48,  48};
        vecs[3] = '{2'd2, 32'h1000_0000, 8'd5,   32'd0,         32'd0,         16'd0, 8'd5,   8'd53,  16};
        vecs[4] = '{2'd1, 32'h1000_0000, 8'd0,   32'h1000_0000, 32'h4000_0000, 16'd0, 8'd0,   8'd48,  34};
        vecs[5] = '{2'd1, 32'h1000_0000, 8'd0,   32'd0,         32'h4000_0000, 16'd0, 8'd0,   8'd48,  16};
        vecs[6] = '{2'd1, 32'h4000_0000, 8'd0,   32'h1000_0000, 32'h1000_0000, 16'd0, 8'd0,   8'd192, 4};
        vecs[7] = '{2'd3, 32'h0800_0000, 8'd1,   32'd0,         32'd0,         16'd0, 8'd1,   8'd25,  0};
        vecs[8] = '{2'd2, 32'h4000_0000, 8'h80,  32'd0,         32'd0,         16'd2, 8'h80,  8'd64,  8};
        vecs[9] = '{2'd1, 32'h8000_0000, 8'd0,   32'hF000_0000, 32'hFFFF_FFFF, 16'd0, 8'd0,   8'd255, 4};

        #1;
        chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_addr_valid", {63'd0, addr_valid}, 64'd0);
        chk("rst_sample_valid", {63'd0, sample_valid}, 64'd0);
        chk("rst_rd_address", {56'd0, rd_address}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // start and stop together in IDLE: stay idle
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_busy", {63'd0, busy}, 64'd0);
        chk("startstop_av", {63'd0, addr_valid}, 64'd0);

        // burst aborted by stop; start ignored in RUN; cfg stalls until IDLE
        b = vecs[2];
        load_cfg(b);
        cfg_valid = 1'b1;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("run_addr5", {56'd0, rd_address}, 64'd80);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_addr6", {56'd0, rd_address}, 64'd96);
        b = vecs[0];
        b.pword = 8'd9;
        load_cfg(b);
        cfg_valid = 1'b1;
        chk("run_cfg_ready_low", {63'd0, cfg_ready}, 64'd0);
        tick();
        chk("run_addr7", {56'd0, rd_address}, 64'd112);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_av", {63'd0, addr_valid}, 64'd0);
        chk("stop_done", {63'd0, done}, 64'd0);
        chk("stop_busy", {63'd0, busy}, 64'd0);
        chk("stop_ready", {63'd0, cfg_ready}, 64'd1);
        chk("stop_sample_valid", {63'd0, sample_valid}, 64'd1);
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (done) chk("stop_no_late_done", {63'd0, done}, 64'd0);
            if (k < 3) tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("newcfg_first", {56'd0, rd_address}, 64'd9);
        tick();
        chk("newcfg_second", {56'd0, rd_address}, 64'd10);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // asynchronous reset mid-sweep
        b = vecs[4];
        b.pword = 8'd7;
        load_cfg(b);
        cfg_valid = 1'b1;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("presreset_busy", {63'd0, busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_av", {63'd0, addr_valid}, 64'd0);
        chk("arst_sv", {63'd0, sample_valid}, 64'd0);
        chk("arst_addr", {56'd0, rd_address}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        #3;
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cfglost_first", {56'd0, rd_address}, 64'd0);
        tick();
        chk("cfglost_second", {56'd0, rd_address}, 64'd0);
        chk("cfglost_valid", {63'd0, addr_valid}, 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
